// File: rtl/apb_uart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_uart_fifo
// Desc     : APB UART with TX/RX FIFOs, watermark interrupts, error flags and
//            a programmable bit period. Parity support: define UART_PARITY_EN.
// Revision : 1.0
// ============================================================================

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot, so a full FIFO still accepts a simultaneous push
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

module apb_uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:2] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RXD,
    output logic        TXD,
    output logic        TXEN,
    output logic        BAUDTICK,
    output logic        TXINT,
    output logic        RXINT,
    output logic        TXOVRINT,
    output logic        RXOVRINT,
    output logic        UARTINT
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    logic [23:0] ctrl;
    logic [19:0] bauddiv;
    logic [19:0] baud_cnt;
    logic        txovr, rxovr, parerr, frmerr;
    logic        par_en, par_odd;
    logic [23:0] ctrl_mask;

`ifdef UART_PARITY_EN
    assign ctrl_mask = 24'hFF_FFFF;
    assign par_en    = ctrl[6];
    assign par_odd   = ctrl[7];
`else
    assign ctrl_mask = 24'hFF_FF3F;
    assign par_en    = 1'b0;
    assign par_odd   = 1'b0;
`endif

    // ---------------- APB decode ----------------
    logic access, wr, rd, mapped, sel_data, sel_state, sel_ctrl, sel_baud, baud_ok;
    assign access    = PSEL & PENABLE;
    assign wr        = access & PWRITE;
    assign rd        = access & ~PWRITE;
    assign sel_data  = (PADDR == 10'd0);
    assign sel_state = (PADDR == 10'd1);
    assign sel_ctrl  = (PADDR == 10'd2);
    assign sel_baud  = (PADDR == 10'd3);
    assign mapped    = sel_data | sel_state | sel_ctrl | sel_baud;
    assign baud_ok   = (PWDATA[19:0] >= 20'd16);
    assign PSLVERR   = wr & (~mapped | (sel_baud & ~baud_ok));
    assign PREADY    = 1'b1;

    // ---------------- FIFOs ----------------
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] tx_rdata, rx_rdata, rx_shift;
    logic [CW-1:0]        tx_count, rx_count;
    logic [7:0]           tx_count8, rx_count8;

    assign tx_push   = wr & sel_data;
    assign rx_pop    = rd & sel_data;
    assign tx_count8 = 8'(tx_count);
    assign rx_count8 = 8'(rx_count);

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .pop(tx_pop), .wdata(PWDATA[DATA_BITS-1:0]),
        .rdata(tx_rdata), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
        .rdata(rx_rdata), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- Registers ----------------
    logic set_parerr, set_frmerr;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl    <= '0;
            bauddiv <= 20'd16;
            txovr   <= 1'b0;
            rxovr   <= 1'b0;
            parerr  <= 1'b0;
            frmerr  <= 1'b0;
        end else begin
            if (wr & sel_ctrl)           ctrl    <= PWDATA[23:0] & ctrl_mask;
            if (wr & sel_baud & baud_ok) bauddiv <= PWDATA[19:0];
            // Setting an error flag wins over a same-cycle write-one-to-clear
            if (tx_push & tx_full & ~tx_pop)            txovr  <= 1'b1;
            else if (wr & sel_state & PWDATA[2])        txovr  <= 1'b0;
            if (rx_push & rx_full & ~(rx_pop & ~rx_empty)) rxovr <= 1'b1;
            else if (wr & sel_state & PWDATA[3])        rxovr  <= 1'b0;
            if (set_parerr)                             parerr <= 1'b1;
            else if (wr & sel_state & PWDATA[5])        parerr <= 1'b0;
            if (set_frmerr)                             frmerr <= 1'b1;
            else if (wr & sel_state & PWDATA[6])        frmerr <= 1'b0;
        end
    end

    logic [31:0] state_word;
    assign state_word = {8'd0, rx_count8, tx_count8, 1'b0, frmerr, parerr, tx_empty,
                         rxovr, txovr, ~rx_empty, tx_full};

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (PADDR)
                10'd0:   PRDATA = rx_empty ? 32'd0 : 32'(rx_rdata);
                10'd1:   PRDATA = state_word;
                10'd2:   PRDATA = {8'd0, ctrl};
                10'd3:   PRDATA = {12'd0, bauddiv};
                default: PRDATA = '0;
            endcase
        end
    end

    // ---------------- Baud tick ----------------
    assign BAUDTICK = (baud_cnt >= bauddiv - 20'd1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)      baud_cnt <= '0;
        else if (BAUDTICK) baud_cnt <= '0;
        else               baud_cnt <= baud_cnt + 20'd1;
    end

    // ---------------- TX FSM ----------------
    uart_state_t          tx_state, tx_next;
    logic [19:0]          tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_bit_end;

    assign tx_bit_end = (tx_cnt >= bauddiv - 20'd1);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:   if (ctrl[0] & ~tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
            S_START:  if (tx_bit_end) tx_next = S_DATA;
            S_DATA:   if (tx_bit_end && tx_bit == LAST_BIT) tx_next = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (tx_bit_end) tx_next = S_STOP;
            S_STOP: begin
                if (tx_bit_end) begin
                    if (ctrl[0] & ~tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
                    else                     tx_next = S_IDLE;
                end
            end
            default:  tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_rdata;
                tx_par   <= ^tx_rdata ^ par_odd;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != S_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 20'd1;
                end
            end
        end
    end

    always_comb begin
        case (tx_state)
            S_START:  TXD = 1'b0;
            S_DATA:   TXD = tx_shift[0];
            S_PARITY: TXD = tx_par;
            default:  TXD = 1'b1;
        endcase
    end
    assign TXEN = (tx_state != S_IDLE);

    // ---------------- RX FSM ----------------
    uart_state_t rx_state, rx_next;
    logic [19:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic        rx_meta, rx_sync, rx_prev, rx_parbit;
    logic        rx_half_hit, rx_full_hit, rx_sample;

    assign rx_half_hit = (rx_cnt >= {1'b0, bauddiv[19:1]} - 20'd1);
    assign rx_full_hit = (rx_cnt >= bauddiv - 20'd1);
    assign rx_sample   = (rx_state == S_START) ? rx_half_hit : rx_full_hit;

    always_comb begin
        rx_next    = rx_state;
        rx_push    = 1'b0;
        set_frmerr = 1'b0;
        set_parerr = 1'b0;
        case (rx_state)
            S_IDLE:   if (ctrl[1] & rx_prev & ~rx_sync) rx_next = S_START;
            S_START:  if (rx_half_hit) rx_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:   if (rx_full_hit && rx_bit == LAST_BIT) rx_next = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (rx_full_hit) rx_next = S_STOP;
            S_STOP: begin
                if (rx_full_hit) begin
                    rx_next = S_IDLE;
                    if (!rx_sync) begin
                        set_frmerr = 1'b1;
                    end else begin
                        rx_push    = 1'b1;
                        set_parerr = par_en & (rx_parbit != (^rx_shift ^ par_odd));
                    end
                end
            end
            default:  rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_parbit <= 1'b0;
        end else begin
            rx_meta  <= RXD;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_next;
            if (rx_state == S_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
            end else if (rx_sample) begin
                rx_cnt <= '0;
                if (rx_state == S_DATA) begin
                    rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
                if (rx_state == S_PARITY) rx_parbit <= rx_sync;
            end else begin
                rx_cnt <= rx_cnt + 20'd1;
            end
        end
    end

    // ---------------- Interrupts ----------------
    assign TXINT    = ctrl[2] & (tx_count8 <= ctrl[15:8]);
    assign RXINT    = ctrl[3] & (rx_count8 >= ctrl[23:16]) & (rx_count8 != 8'd0);
    assign TXOVRINT = txovr & ctrl[4];
    assign RXOVRINT = rxovr & ctrl[5];
    assign UARTINT  = TXINT | RXINT | TXOVRINT | RXOVRINT;

    logic unused_bits;
    assign unused_bits = ^{PWDATA[31:24], ctrl[7:6]};
endmodule

`default_nettype wire

// File: tb/tb_apb_uart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_uart_fifo
// Desc     : Scoreboard bench for apb_uart_fifo (TX/RX data, flags, APB errors).
// Revision : 1.0
// ============================================================================

module tb_apb_uart_fifo;
    localparam int DIV = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:2] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        RXD = 1'b1;
    logic        TXD, TXEN, BAUDTICK, TXINT, RXINT, TXOVRINT, RXOVRINT, UARTINT;

    apb_uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .RXD(RXD), .TXD(TXD), .TXEN(TXEN), .BAUDTICK(BAUDTICK), .TXINT(TXINT), .RXINT(RXINT),
        .TXOVRINT(TXOVRINT), .RXOVRINT(RXOVRINT), .UARTINT(UARTINT)
    );

    always #5 PCLK = ~PCLK;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr[11:2]; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr[11:2];
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 begin data = PRDATA; err = PSLVERR; end
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Waits for a start bit, then samples each of the 10 bit cells mid-cell.
    task automatic tx_capture(output logic [9:0] frame, output int waited, output int txen_cnt);
        frame = '0; waited = 0; txen_cnt = 0;
        do begin
            @(negedge PCLK);
            waited++;
        end while (TXD !== 1'b0 && waited < 2000);
        if (TXD !== 1'b0) begin
            check("tx_start_timeout", 32'd0, 32'd1);
            waited = -1;
            return;
        end
        for (int c = 0; c < 10 * DIV; c++) begin
            if (c != 0) @(negedge PCLK);
            if (TXEN === 1'b1) txen_cnt++;
            if (c % DIV == DIV / 2) frame[c / DIV] = TXD;
        end
    endtask

    task automatic rx_bit(input logic b);
        RXD = b;
        repeat (DIV) @(negedge PCLK);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input logic par_on, input logic par_val);
        @(negedge PCLK);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        if (par_on) rx_bit(par_val);
        rx_bit(stop);
        RXD = 1'b1;
        repeat (4) @(negedge PCLK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        logic        err;
        logic [9:0]  frame;
        int          waited, txen_cnt, gap;
        logic [7:0]  b;

        repeat (3) @(negedge PCLK);
        check("rst_txd", TXD, 1);
        check("rst_txen", TXEN, 0);
        check("rst_int", {TXINT, RXINT, TXOVRINT, RXOVRINT, UARTINT}, 0);
        check("rst_prdata", PRDATA, 0);
        check("rst_pslverr", PSLVERR, 0);
        PRESETn = 1'b1;
        apb_read(12'h004, rdat, err);
        check("rst_state", rdat, 32'h10);
        apb_read(12'h00C, rdat, err);
        check("rst_bauddiv", rdat, 16);

        // Single TX character
        apb_write(12'h00C, 16, err);
        check("baud16_err", err, 0);
        apb_write(12'h008, 32'h1, err);
        apb_write(12'h000, 32'hCD, err);
        tx_q.push_back(8'hCD);
        tx_capture(frame, waited, txen_cnt);
        check("tx_latency", waited, 2);
        check("tx_frame", frame, {1'b1, tx_q.pop_front(), 1'b0});
        check("txen_len", txen_cnt, 160);
        @(negedge PCLK);
        check("txen_off", TXEN, 0);

        // TX overrun with transmitter disabled
        apb_write(12'h008, 32'h10, err);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            apb_write(12'h000, {24'd0, b}, err);
            if (i < 8) tx_q.push_back(b);
        end
        apb_read(12'h004, rdat, err);
        check("state_txovr", rdat, 32'h0805);
        check("txovrint", TXOVRINT, 1);
        check("uartint", UARTINT, 1);
        apb_write(12'h004, 32'h4, err);
        apb_read(12'h004, rdat, err);
        check("state_txovr_clr", rdat, 32'h0801);
        check("txovrint_clr", TXOVRINT, 0);

        // Drain the 8 queued characters back-to-back
        apb_write(12'h008, 32'h1, err);
        for (int i = 0; i < 8; i++) begin
            tx_capture(frame, waited, txen_cnt);
            if (waited < 0) break;
            check("tx_fifo_frame", frame, {1'b1, tx_q.pop_front(), 1'b0});
        end
        @(negedge PCLK);
        apb_write(12'h008, 32'h4, err);
        check("txint_empty", TXINT, 1);

        // Single RX character with watermark interrupt
        apb_write(12'h008, 32'h0001_000A, err);
        rx_send(8'h93, 1'b1, 1'b0, 1'b0);
        rx_q.push_back(8'h93);
        check("rxint_set", RXINT, 1);
        apb_read(12'h000, rdat, err);
        check("rx_data", rdat, {24'd0, rx_q.pop_front()});
        check("rxint_clr", RXINT, 0);

        // Start-bit glitch is ignored
        @(negedge PCLK);
        RXD = 1'b0;
        repeat (4) @(negedge PCLK);
        RXD = 1'b1;
        repeat (2 * DIV) @(negedge PCLK);
        apb_read(12'h004, rdat, err);
        check("rx_glitch", rdat, 32'h10);

        // RX overrun: 9 characters, no reads
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1, 1'b0, 1'b0);
            if (i < 8) rx_q.push_back(b);
        end
        apb_read(12'h004, rdat, err);
        check("state_rxovr", rdat, 32'h0008_001A);
        while (rx_q.size() > 0) begin
            apb_read(12'h000, rdat, err);
            check("rx_fifo_data", rdat, {24'd0, rx_q.pop_front()});
        end
        apb_read(12'h000, rdat, err);
        check("rx_empty_read", rdat, 0);
        apb_write(12'h004, 32'h8, err);
        apb_read(12'h004, rdat, err);
        check("rxovr_clr", rdat, 32'h10);

        // Framing error
        rx_send(8'h55, 1'b0, 1'b0, 1'b0);
        apb_read(12'h004, rdat, err);
        check("state_frmerr", rdat, 32'h50);
        apb_write(12'h004, 32'h40, err);
        apb_read(12'h004, rdat, err);
        check("frmerr_clr", rdat, 32'h10);

`ifdef UART_PARITY_EN
        apb_write(12'h008, 32'hC2, err);
        apb_read(12'h008, rdat, err);
        check("ctrl_par_bits", rdat, 32'hC2);
        // Even parity, 0xA5 has even weight so the correct bit is 0
        apb_write(12'h008, 32'h42, err);
        rx_send(8'hA5, 1'b1, 1'b1, 1'b1);
        rx_q.push_back(8'hA5);
        apb_read(12'h004, rdat, err);
        check("state_parerr", rdat, 32'h0001_0032);
        apb_read(12'h000, rdat, err);
        check("rx_par_data", rdat, {24'd0, rx_q.pop_front()});
`else
        apb_write(12'h008, 32'hC2, err);
        apb_read(12'h008, rdat, err);
        check("ctrl_par_bits", rdat, 32'h02);
`endif

        // APB error responses
        apb_write(12'h00C, 12, err);
        check("baud12_err", err, 1);
        apb_read(12'h00C, rdat, err);
        check("baud_kept", rdat, 16);
        apb_write(12'h010, 32'h1234, err);
        check("unmapped_wr_err", err, 1);
        apb_read(12'h010, rdat, err);
        check("unmapped_rd", rdat, 0);
        check("unmapped_rd_err", err, 0);
        apb_write(12'h00C, 20, err);
        apb_read(12'h00C, rdat, err);
        check("baud20", rdat, 20);
        apb_write(12'h00C, 16, err);

        // BAUDTICK period
        gap = 0;
        do begin @(negedge PCLK); gap++; end while (BAUDTICK !== 1'b1 && gap < 100);
        gap = 0;
        do begin @(negedge PCLK); gap++; end while (BAUDTICK !== 1'b1 && gap < 100);
        check("baudtick_period", gap, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/apb_uart_fifo.md
# apb_uart_fifo

APB-mapped UART with parametrised transmit/receive FIFOs, configurable character width and optional parity. It replaces the single-buffer APB UART in the peripheral subsystem and adds watermark interrupts, framing/parity error detection and a programmable bit period. It sits on the APB bus next to the timers; TX/RX pins go to the pad ring.

## Interface
Parameters:
- DATA_BITS, 8, character width in bits; legal range 5..8.
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  [11:2]  word address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; 0 when not in a read access phase.
- PREADY  out  1  tied 1; zero wait states.
- PSLVERR  out  1  error response.
- RXD  in  1  serial input, idle high; double-flop synchronised internally.
- TXD  out  1  serial output, idle high.
- TXEN  out  1  high while a TX frame is on the line.
- BAUDTICK  out  1  one-cycle pulse per bit period.
- TXINT, RXINT, TXOVRINT, RXOVRINT  out  1 each  individual interrupts.
- UARTINT  out  1  OR of the four interrupts.

## Operation
- Registers, by byte offset:
  - 0x000 DATA: write pushes TX FIFO; read pops RX FIFO, returns 0 with no pop when empty.
  - 0x004 STATE: [0] TX full, [1] RX not empty, [2] TXOVR, [3] RXOVR, [4] TX empty, [5] PARERR, [6] FRMERR, [15:8] TX count, [23:16] RX count. Writing 1 clears bits 2, 3, 5, 6.
  - 0x008 CTRL, read/write, reset 0: [0] TX enable, [1] RX enable, [2] TXIE, [3] RXIE, [4] TXOVRIE, [5] RXOVRIE, [6] parity enable, [7] odd parity, [15:8] TX watermark, [23:16] RX watermark.
  - 0x00C BAUDDIV: [19:0] cycles per bit; reset 16.
- PSLVERR is asserted in the access phase for:
  - any write to an unmapped offset (no state change);
  - a BAUDDIV write below 16 (value not updated).
  - Unmapped reads return 0 with PSLVERR=0.
- Frame format: start(0), DATA_BITS LSB-first, optional parity bit, one stop(1).
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Leaves IDLE when TX enable is set and the TX FIFO is not empty; the entry is popped on that transition.
  - Each state lasts one bit period. PARITY is skipped when disabled.
  - STOP returns to IDLE, or to START directly if the FIFO is still non-empty.
  - Clearing TX enable mid-frame completes the current frame.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - A falling edge on synchronised RXD while RX enable is set starts a frame.
  - The line is sampled at BAUDDIV>>1 cycles after the edge. If it is high at that point, the event is a glitch and the FSM returns to IDLE.
  - Subsequent samples are taken every BAUDDIV cycles.
  - Stop bit = 0: FRMERR set, character discarded.
  - Parity mismatch: PARERR set, character still pushed.
  - A push to a full FIFO sets RXOVR and drops the new character.
- TX write to a full FIFO sets TXOVR and drops the data.
- Interrupts are level signals:
  - TXINT = TXIE & (TX count <= TX watermark).
  - RXINT = RXIE & (RX count >= RX watermark, and count != 0).
  - TXOVRINT = TXOVR & TXOVRIE; RXOVRINT = RXOVR & RXOVRIE.
- Counts are $clog2(FIFO_DEPTH)+1 bits wide, zero-extended into 8-bit fields. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Write takes effect on the PCLK edge ending the access phase (PSEL & PENABLE & PWRITE). A read pops on the same edge.
- PRDATA and PSLVERR are combinational during the access phase.
- A TX FIFO push reaches TXD (start bit) 1 cycle later when the TX FSM is idle and enabled.
- An RX character is visible in STATE[1] 1 cycle after the stop-bit sample.
- Simultaneous push and pop on a full FIFO: both accepted, count unchanged, no overrun. On an empty FIFO a read-pop is ignored while the push still succeeds.
- Bit counter resets on every TX frame start and RX start edge. BAUDTICK pulses when the free-running divider wraps.
- Reset values (PRESETn low, asynchronous):
  - TXD=1; TXEN=0.
  - All interrupts 0; PRDATA=0; PSLVERR=0.
  - FIFOs empty; FSMs IDLE; sticky flags 0.
  - Reset mid-frame aborts the frame immediately.

## Configuration
- UART_PARITY_EN defined: parity logic, CTRL[7:6], STATE[5] and the PARITY states are present.
- UART_PARITY_EN undefined: CTRL[7:6] and STATE[5] read 0 and ignore writes; frames never carry a parity bit.

## Test plan
- Set BAUDDIV=16, CTRL=0x01, write DATA 0xCD → TXD shows 0,1,0,1,1,0,0,1,1,1, each bit 16 cycles; TXEN high 160 cycles.
- Set TX enable=0, write 9 bytes with FIFO_DEPTH=8 → STATE[2]=1, count=8; with TXOVRIE=1, TXOVRINT=1; writing STATE=0x4 clears it.
- RX enable, drive 0x93 frame at 16 cycles/bit → read DATA returns 0x93; RXINT=1 with RX watermark 1 until the read.
- Drive 9 frames with no reads → RXOVR=1, first 8 characters read back in order.
- Drive a frame with stop=0 → FRMERR=1, RX count 0. With UART_PARITY_EN, even parity and a wrong parity bit → PARERR=1, character stored.
- Write BAUDDIV=12 → PSLVERR=1, BAUDDIV reads 16. Write to 0x010 → PSLVERR=1.
